// File: rtl/memory_stage.sv
// ============================================================================
// memory_stage
// ----------------------------------------------------------------------------
// This is the fourth stage of the 5-stage pipeline. It takes the Execute stage
// outputs, performs loads and stores on an internal word-addressed 16-bit data
// memory, and registers the result at the MEM/WB boundary toward Writeback.
//
// A 32-bit (wide) access is split over two cycles:
//   - IDLE edge:   handles the low word.
//   - SECOND edge: handles the high word at idx+1, which wraps modulo DEPTH.
// While a wide access is accepted, the stage stalls the upstream stages for
// one cycle.
//
// Optional feature macro: MEM_BOUNDS_CHECK_EN
//   defined   : out-of-range memory ops raise mem_fault, suppress writes,
//               and make loads return 0.
//   undefined : the address wraps to ADDR_W bits and mem_fault is tied to 0.
//
// Ports
//   clk          in   clock, rising-edge
//   rst          in   asynchronous reset, active-high
//   ex_valid     in   Execute presents a valid instruction
//   mem_read     in   load
//   mem_write    in   store (wins if mem_read is also set)
//   mem_wide     in   32-bit access for memory ops
//   reg_write    in   instruction writes a register
//   dest[2:0]    in   destination register index
//   alu_result   in   memory address, or pass-through data
//   store_data   in   store data; a narrow store uses [15:0]
//   stall        out  combinational; hold Execute and earlier stages
//   wb_valid     out  registered; wb_* fields are valid
//   wb_reg_write out  registered reg_write
//   wb_dest      out  registered dest
//   wb_data      out  registered writeback data
//   mem_fault    out  registered bounds fault (MEM_BOUNDS_CHECK_EN only)
// ============================================================================
module memory_stage #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_wide,
    input  logic        reg_write,
    input  logic [2:0]  dest,
    input  logic [15:0] alu_result,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [2:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        mem_fault
);

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } stateT;

    stateT r_state;
    stateT w_nextState;

    logic [15:0] r_mem [DEPTH];

    // Operation latched on entry to SECOND. Upstream holds its inputs during
    // SECOND, but those inputs are deliberately ignored there.
    logic [ADDR_W-1:0] r_idx;
    logic              r_isRead;
    logic              r_isWrite;
    logic              r_regWrite;
    logic [2:0]        r_dest;
    logic [15:0]       r_storeHi;
    logic [15:0]       r_loLoad;
    logic [31:0]       r_wbHold;
    logic              r_fault;

    logic              w_memOp;
    logic              w_startWide;
    logic [ADDR_W-1:0] w_idx;
    logic [ADDR_W-1:0] w_idxHi;
    logic [15:0]       w_rdData;
    logic [15:0]       w_rdDataHi;
    logic [31:0]       w_narrowData;
    logic              w_fault;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_memAddr;
    logic [15:0]       w_memWdata;

    assign w_memOp     = ex_valid & (mem_read | mem_write);
    assign w_startWide = w_memOp & mem_wide;
    assign w_idx       = alu_result[ADDR_W-1:0];
    // The high-word index wraps naturally because of the ADDR_W width.
    assign w_idxHi     = r_idx + 1'b1;
    assign w_rdData    = r_mem[w_idx];
    assign w_rdDataHi  = r_mem[w_idxHi];

`ifdef MEM_BOUNDS_CHECK_EN
    logic [16:0] w_lastAddr;

    // A wide op faults if its second word would fall past the end of memory.
    assign w_lastAddr = {1'b0, alu_result} + (mem_wide ? 17'd1 : 17'd0);
    assign w_fault    = w_memOp & (w_lastAddr >= 17'(DEPTH));
`else
    logic w_unusedUpper;

    assign w_fault       = 1'b0;
    assign w_unusedUpper = ^alu_result[15:ADDR_W];
`endif

    // Writeback data for a single-cycle op. When both read and write are set,
    // the store wins and the store value is written back.
    always_comb begin
        w_narrowData = {16'h0, alu_result};
        if (mem_write && mem_read) begin
            w_narrowData = {16'h0, store_data[15:0]};
        end else if (mem_read) begin
            w_narrowData = w_fault ? 32'h0 : {16'h0, w_rdData};
        end
    end

    // The state register sits alone, so that an asynchronous reset abandons
    // any second half that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and stall. The stall covers only the accepting cycle,
    // because by the SECOND cycle the op has already been captured.
    always_comb begin
        w_nextState = r_state;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                stall = w_startWide;
                if (w_startWide) begin
                    w_nextState = SECOND;
                end
            end
            SECOND: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Memory write port. Writes are blocked while reset is held, so a reset
    // during a wide op never commits the second word.
    always_comb begin
        w_memWe    = 1'b0;
        w_memAddr  = w_idx;
        w_memWdata = store_data[15:0];
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    w_memWe = ex_valid & mem_write & ~w_fault;
                end
                SECOND: begin
                    w_memWe    = r_isWrite & ~r_fault;
                    w_memAddr  = w_idxHi;
                    w_memWdata = r_storeHi;
                end
                default: begin
                    w_memWe = 1'b0;
                end
            endcase
        end
    end

    // Memory contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_memAddr] <= w_memWdata;
        end
    end

    // MEM/WB register and the wide-op holding registers. After the first edge
    // of a wide op, wb_valid drops for a bubble while the other wb_* fields
    // hold their values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_dest      <= 3'd0;
            wb_data      <= 32'h0;
            r_idx        <= '0;
            r_isRead     <= 1'b0;
            r_isWrite    <= 1'b0;
            r_regWrite   <= 1'b0;
            r_dest       <= 3'd0;
            r_storeHi    <= 16'h0;
            r_loLoad     <= 16'h0;
            r_wbHold     <= 32'h0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ex_valid && w_startWide) begin
                        wb_valid   <= 1'b0;
                        r_idx      <= w_idx;
                        r_isRead   <= mem_read & ~mem_write;
                        r_isWrite  <= mem_write;
                        r_regWrite <= reg_write;
                        r_dest     <= dest;
                        r_storeHi  <= store_data[31:16];
                        r_loLoad   <= w_rdData;
                        r_wbHold   <= (mem_read && mem_write) ? store_data
                                                              : {16'h0, alu_result};
                        r_fault    <= w_fault;
                    end else if (ex_valid) begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= reg_write;
                        wb_dest      <= dest;
                        wb_data      <= w_narrowData;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                SECOND: begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= r_regWrite;
                    wb_dest      <= r_dest;
                    if (r_isRead) begin
                        wb_data <= r_fault ? 32'h0 : {w_rdDataHi, r_loLoad};
                    end else begin
                        wb_data <= r_wbHold;
                    end
                end
                default: begin
                    wb_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    logic w_resultNow;
    logic w_resultFault;

    // The fault flag follows each produced result and holds between results.
    assign w_resultNow   = (r_state == SECOND) | (ex_valid & ~w_startWide);
    assign w_resultFault = (r_state == SECOND) ? r_fault : w_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_fault <= 1'b0;
        end else if (w_resultNow) begin
            mem_fault <= w_resultFault;
        end
    end
`else
    assign mem_fault = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// ============================================================================
// tb_memory_stage
// ----------------------------------------------------------------------------
// Directed testbench for memory_stage. Each issued instruction pushes its
// hand-computed writeback onto a queue, and a monitor on the falling edge
// pops and compares the queue whenever wb_valid is high.
// ============================================================================
module tb_memory_stage;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        mem_read;
    logic        mem_write;
    logic        mem_wide;
    logic        reg_write;
    logic [2:0]  dest;
    logic [15:0] alu_result;
    logic [31:0] store_data;
    logic        stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [2:0]  wb_dest;
    logic [31:0] wb_data;
    logic        mem_fault;

    typedef struct packed {
        logic        regw;
        logic [2:0]  dest;
        logic [31:0] data;
        logic        fault;
    } expT;

    expT expQ[$];
    int  passCount  = 0;
    int  checkCount = 0;

    memory_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wide    (mem_wide),
        .reg_write   (reg_write),
        .dest        (dest),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_reg_write(wb_reg_write),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .mem_fault   (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // This task drives one instruction and pushes its expected writeback.
    // For a wide memory op, it holds the inputs through the SECOND cycle and
    // checks both the one-cycle stall and the bubble.
    task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                                 input logic wide, input logic rw,
                                 input logic [2:0] d, input logic [15:0] a,
                                 input logic [31:0] sd,
                                 input logic [31:0] expData, input logic expFault);
        expT e;
        logic isWide;
        isWide     = v & (rd | wr) & wide;
        ex_valid   = v;
        mem_read   = rd;
        mem_write  = wr;
        mem_wide   = wide;
        reg_write  = rw;
        dest       = d;
        alu_result = a;
        store_data = sd;
        #1;
        checkOutput("stall_accept", 32'(stall), 32'(isWide));
        if (v) begin
            e.regw  = rw;
            e.dest  = d;
            e.data  = expData;
            e.fault = expFault;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        if (isWide) begin
            checkOutput("bubble_wb_valid", 32'(wb_valid), 32'd0);
            checkOutput("stall_second", 32'(stall), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // The monitor is decoupled from the stimulus. Every valid result must
    // match the oldest expectation in the queue.
    always @(negedge clk) begin : monitor
        expT e;
        if (!rst && wb_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("result_expected", 32'(expQ.size()), 32'd1);
            end else begin
                e = expQ.pop_front();
                checkOutput("wb_data", wb_data, e.data);
                checkOutput("wb_dest", 32'(wb_dest), 32'(e.dest));
                checkOutput("wb_reg_write", 32'(wb_reg_write), 32'(e.regw));
                checkOutput("mem_fault", 32'(mem_fault), 32'(e.fault));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst        = 1'b1;
        ex_valid   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wide   = 1'b0;
        reg_write  = 1'b0;
        dest       = 3'd0;
        alu_result = 16'h0;
        store_data = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        checkOutput("rst_wb_dest", 32'(wb_dest), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'h0);
        checkOutput("rst_mem_fault", 32'(mem_fault), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // This section stores narrow then loads it back, plus a pass-through.
        applyStimulus(1, 0, 1, 0, 0, 3'd0, 16'd5, 32'h0000BEEF, 32'h00000005, 0);
        applyStimulus(1, 1, 0, 0, 1, 3'd2, 16'd5, 32'h0, 32'h0000BEEF, 0);

        // This section stores wide at 8 and reads it back wide and narrow.
        applyStimulus(1, 0, 1, 1, 0, 3'd0, 16'd8, 32'h12345678, 32'h00000008, 0);
        applyStimulus(1, 1, 0, 1, 1, 3'd4, 16'd8, 32'h0, 32'h12345678, 0);
        applyStimulus(1, 1, 0, 0, 1, 3'd1, 16'd9, 32'h0, 32'h00001234, 0);
        applyStimulus(1, 1, 0, 0, 1, 3'd1, 16'd8, 32'h0, 32'h00005678, 0);

        // This section issues an ALU pass-through, then an idle cycle that
        // must hold the fields.
        applyStimulus(1, 0, 0, 0, 1, 3'd3, 16'h00F3, 32'h0, 32'h000000F3, 0);
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("idle_hold_dest", 32'(wb_dest), 32'd3);
        checkOutput("idle_hold_data", wb_data, 32'h000000F3);
        checkOutput("idle_hold_regw", 32'(wb_reg_write), 32'd1);

        // When read and write are both set, the store wins (narrow and wide).
        applyStimulus(1, 1, 1, 0, 1, 3'd5, 16'd30, 32'h0000CAFE, 32'h0000CAFE, 0);
        applyStimulus(1, 1, 0, 0, 1, 3'd5, 16'd30, 32'h0, 32'h0000CAFE, 0);
        applyStimulus(1, 1, 1, 1, 1, 3'd6, 16'd40, 32'hDEAD1234, 32'hDEAD1234, 0);
        applyStimulus(1, 1, 0, 1, 1, 3'd6, 16'd40, 32'h0, 32'hDEAD1234, 0);

`ifndef MEM_BOUNDS_CHECK_EN
        // This section checks the wide wrap at DEPTH-1 and that the upper
        // address bits are ignored.
        applyStimulus(1, 0, 1, 1, 0, 3'd0, 16'h03FF, 32'hAAAA5555, 32'h000003FF, 0);
        applyStimulus(1, 1, 0, 0, 1, 3'd7, 16'h03FF, 32'h0, 32'h00005555, 0);
        applyStimulus(1, 1, 0, 0, 1, 3'd7, 16'h0000, 32'h0, 32'h0000AAAA, 0);
        applyStimulus(1, 1, 0, 1, 1, 3'd7, 16'h03FF, 32'h0, 32'hAAAA5555, 0);
        applyStimulus(1, 1, 0, 0, 1, 3'd2, 16'h0409, 32'h0, 32'h00001234, 0);
`else
        // This section checks that an out-of-range store is suppressed and
        // an out-of-range load returns zero.
        applyStimulus(1, 0, 1, 0, 0, 3'd0, 16'h0400, 32'h00007777, 32'h00000400, 1);
        applyStimulus(1, 1, 0, 0, 1, 3'd2, 16'h0400, 32'h0, 32'h00000000, 1);
        applyStimulus(1, 1, 0, 0, 1, 3'd2, 16'h0005, 32'h0, 32'h0000BEEF, 0);
`endif

        // This section pulses reset in the SECOND cycle of a wide store.
        applyStimulus(1, 0, 1, 0, 0, 3'd0, 16'd21, 32'h00001111, 32'h00000015, 0);
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        ex_valid   = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        mem_wide   = 1'b1;
        reg_write  = 1'b0;
        dest       = 3'd1;
        alu_result = 16'd20;
        store_data = 32'h22223333;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("midrst_wb_data", wb_data, 32'h0);
        checkOutput("midrst_wb_dest", 32'(wb_dest), 32'd0);
        checkOutput("midrst_wb_regw", 32'(wb_reg_write), 32'd0);
        checkOutput("midrst_mem_fault", 32'(mem_fault), 32'd0);
        checkOutput("midrst_state_idle_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 1, 0, 0, 1, 3'd3, 16'd21, 32'h0, 32'h00001111, 0);
        applyStimulus(1, 1, 0, 0, 1, 3'd3, 16'd20, 32'h0, 32'h00003333, 0);

        ex_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Fourth stage of the 5-stage pipeline. Consumes the Execute stage outputs (ALU result as address or pass-through data, store data, memory/writeback controls).
- Performs load/store on an internal word-addressed 16-bit data memory and registers the result toward Writeback (MEM/WB boundary).
- Supports 32-bit (wide) accesses split over two cycles, stalling upstream stages for one cycle.

Parameters:
- DEPTH, 1024, data-memory depth in 16-bit words; power of two.
- ADDR_W, 10, log2(DEPTH); index width into memory.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- ex_valid  in  1  Execute presents a valid instruction this cycle.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_wide  in  1  32-bit access (two words) when mem_read or mem_write is set.
- reg_write  in  1  instruction writes a register.
- dest  in  3  destination register index.
- alu_result  in  16  address for memory ops; pass-through data otherwise.
- store_data  in  32  store data; narrow store uses [15:0].
- stall  out  1  combinational; hold Execute and earlier stages.
- wb_valid  out  1  registered; wb_* fields are valid.
- wb_reg_write  out  1  registered reg_write.
- wb_dest  out  3  registered dest.
- wb_data  out  32  registered writeback data.
- mem_fault  out  1  registered; only with MEM_BOUNDS_CHECK_EN.

Behaviour:
- Reset (async, rst=1): state=IDLE; wb_valid, wb_reg_write, wb_dest, wb_data, mem_fault all 0. Memory contents are not reset. Reset mid-wide-op abandons the second half; the second word is not written.
- Address: idx = alu_result[ADDR_W-1:0]. Upper bits are ignored unless the optional feature is enabled.
- State machine:
  - IDLE -> SECOND when ex_valid & (mem_read|mem_write) & mem_wide.
  - SECOND -> IDLE unconditionally.
- stall = ex_valid & (mem_read|mem_write) & mem_wide & state==IDLE. Upstream holds its inputs through the SECOND cycle. Inputs seen in SECOND are ignored; the op latched at entry is used.
- Non-memory op (ex_valid, no read/write): next cycle wb_valid=1, wb_data={16'h0, alu_result}. Latency 1.
- Narrow store: mem[idx] <= store_data[15:0] at the edge. Next cycle wb_valid=1, wb_data={16'h0, alu_result}.
- Narrow load: next cycle wb_data={16'h0, mem[idx]}, wb_valid=1. Latency 1.
- Wide store:
  - Edge 1 (IDLE): mem[idx] <= store_data[15:0].
  - Edge 2 (SECOND): mem[idx+1] <= store_data[31:16].
  - wb_valid=1 only after edge 2. Latency 2.
- Wide load: wb_data = {mem[idx+1], mem[idx]}, wb_valid=1 after edge 2. Latency 2. The low word is captured at edge 1 in an internal holding register.
- idx+1 wraps modulo DEPTH (DEPTH-1 -> 0).
- After edge 1 of a wide op, wb_valid=0 (bubble).
- ex_valid=0 in IDLE: next cycle wb_valid=0; wb_data, wb_dest and wb_reg_write hold their previous values.
- mem_read & mem_write both set: the store wins, no load occurs, wb_data takes the store value, and the width follows mem_wide.
- Store followed immediately by a load of the same word returns the new data (write committed on the earlier edge).

Optional Feature:
- MEM_BOUNDS_CHECK_EN defined:
  - A memory op whose alu_result >= DEPTH (or, for a wide op, alu_result+1 >= DEPTH) sets mem_fault=1 with the same latency as wb_valid.
  - The write is suppressed (neither word is written), and a load returns wb_data=0. The wide FSM still takes two cycles.
  - mem_fault clears on the next result or on reset.
- Not defined: no bounds check, index wraps, and mem_fault is tied to 0.

Test Plan:
- Reset mid-wide store (rst pulsed in SECOND), then narrow load of idx+1 -> old contents, state IDLE, all wb_* = 0 during reset.
- Narrow store 16'hBEEF to addr 5, next cycle narrow load addr 5 -> wb_data=32'h0000BEEF one cycle after load; stall stays 0 throughout.
- Wide store 32'h12345678 to addr 8 -> stall=1 for exactly one cycle; mem[8]=16'h5678, mem[9]=16'h1234. Wide load addr 8 -> wb_data=32'h12345678 after 2 cycles; wb_valid low in the bubble cycle.
- Wide store 32'hAAAA5555 at addr DEPTH-1 (no feature) -> mem[DEPTH-1]=16'h5555, mem[0]=16'hAAAA.
- ALU op alu_result=16'h00F3, dest=3, reg_write=1 -> next cycle wb_valid=1, wb_data=32'h000000F3, wb_dest=3.
- With MEM_BOUNDS_CHECK_EN, store to 16'h0400 (DEPTH=1024) -> mem_fault=1, no memory change; load from 16'h0400 -> wb_data=0, mem_fault=1.
